// File: rtl/iob_ethoc_pkg.sv
// Shared definitions for the IOb-to-Wishbone bridge in front of the Ethernet MAC.
package iob_ethoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB_REQ = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [31:0] ETHOC_TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam logic [11:0] ETHOC_MODER_OFFSET = 12'h000;
    localparam logic [11:0] ETHOC_TX_BD_BASE   = 12'h400;
    localparam logic [11:0] ETHOC_RX_BD_BASE   = 12'h600;

endpackage

// File: rtl/iob_ethoc_wb_bridge_if.sv
// IOb native bus and classic Wishbone bus bundles used by the bridge ports.
interface iob_ethoc_iob_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;
    logic                  err_o;

    modport master (output valid, address, wdata, wstrb, input rdata, ready, err_o);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready, err_o);
endinterface

interface iob_ethoc_wb_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]     wb_adr_o;
    logic [DATA_W-1:0]     wb_dat_o;
    logic [DATA_W/8-1:0]   wb_sel_o;
    logic                  wb_we_o;
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic [DATA_W-1:0]     wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;

    modport master (output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
                    input  wb_dat_i, wb_ack_i, wb_err_i);
    modport slave  (input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
                    output wb_dat_i, wb_ack_i, wb_err_i);
endinterface

// File: rtl/iob_ethoc_timeout_cnt.sv
// Loadable up-counter that flags the LIMIT-th enabled cycle since the last clear.
module iob_ethoc_timeout_cnt #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LIMIT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);
    logic [CNT_W-1:0] count;

    // count holds the number of enabled cycles already elapsed, so the
    // LIMIT-th cycle is the one where count equals LIMIT-1.
    assign expired = (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/iob_ethoc_wb_bridge.sv
// Converts single IOb native requests into classic Wishbone cycles with a timeout guard.
module iob_ethoc_wb_bridge
    import iob_ethoc_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic            clk_i,
    input logic            rst_i,
    iob_ethoc_iob_if.slave iob,
    iob_ethoc_wb_if.master wb
);
    localparam int unsigned SEL_W = DATA_W / 8;

    state_t              state, state_nxt;
    logic                accept, capture, cap_err, expired;
    logic [DATA_W-1:0]   cap_data;

    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic [SEL_W-1:0]    sel_q;
    logic                we_q;
    logic                stb_q;
    logic                ready_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    iob_ethoc_timeout_cnt #(
        .CNT_W (16),
        .LIMIT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (accept),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == ST_WB_REQ),
        .expired  (expired)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        cap_err   = 1'b0;
        cap_data  = '0;
        case (state)
            ST_IDLE: begin
                if (iob.valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_WB_REQ;
                end
            end
            ST_WB_REQ: begin
                if (wb.wb_ack_i) begin
                    capture  = 1'b1;
                    cap_data = we_q ? '0 : wb.wb_dat_i;
                end else if (wb.wb_err_i) begin
                    capture = 1'b1;
                    cap_err = 1'b1;
                end else if (expired) begin
                    capture  = 1'b1;
                    cap_err  = 1'b1;
                    cap_data = DATA_W'(ETHOC_TIMEOUT_DATA);
                end
                if (capture) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Strobe, ready and error are registered from the next state so every
    // output comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                adr_q <= {iob.address[ADDR_W-1:2], 2'b00};
                dat_q <= iob.wdata;
                sel_q <= (|iob.wstrb) ? iob.wstrb : '1;
                we_q  <= |iob.wstrb;
            end
            stb_q   <= (state_nxt == ST_WB_REQ);
            ready_q <= (state_nxt == ST_RESP);
            err_q   <= capture && cap_err;
            if (capture) begin
                rdata_q <= cap_data;
            end
        end
    end

    assign iob.rdata   = rdata_q;
    assign iob.ready   = ready_q;
    assign iob.err_o   = err_q;

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = stb_q;
    assign wb.wb_stb_o = stb_q;
endmodule

// File: doc/iob_ethoc_wb_bridge.md
# iob_ethoc_wb_bridge

IOb-native-to-Wishbone bridge that answers the IOb native bus (valid/address/wdata/wstrb → rdata/ready) on behalf of the Ethernet MAC register and buffer-descriptor space. It sits between the system IOb interconnect (or a bench initiator) and the MAC's Wishbone slave port. It accepts one-cycle `valid` pulses, runs one classic Wishbone cycle per request, and returns a one-cycle `ready` with read data. A timeout counter guards against a slave that never acknowledges.

## Interface
- `ADDR_W`, 12: IOb byte-address width; also the Wishbone address width.
- `DATA_W`, 32: data width; only 32 is supported.
- `TIMEOUT`, 255: cycles in `WB_REQ` before forced termination; range 1..65535.
- `clk_i` in 1: single clock for both sides.
- `rst_i` in 1: reset, synchronous, active-high.
- `valid` in 1: request strobe, sampled only in `IDLE`.
- `address` in ADDR_W: byte address.
- `wdata` in DATA_W: write data.
- `wstrb` in DATA_W/8: byte enables; 0 = read, nonzero = write.
- `rdata` out DATA_W: read data, valid only while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `err_o` out 1: pulses with `ready` when the request ended by `wb_err_i` or timeout.
- `wb_adr_o` out ADDR_W: `{address[ADDR_W-1:2],2'b00}`.
- `wb_dat_o` out DATA_W: latched `wdata`.
- `wb_sel_o` out DATA_W/8: latched `wstrb`; 4'hF on reads.
- `wb_we_o` out 1: 1 when latched `wstrb` != 0.
- `wb_cyc_o` out 1: bus cycle; always equal to `wb_stb_o`.
- `wb_stb_o` out 1: strobe.
- `wb_dat_i` in DATA_W: slave read data.
- `wb_ack_i` in 1: slave acknowledge.
- `wb_err_i` in 1: slave error.

## Operation
- FSM states: `IDLE`, `WB_REQ`, `RESP`.
- `IDLE`: if `valid`=1, latch address, wdata, wstrb and `we` (`|wstrb`), clear the timeout counter, and go to `WB_REQ`. Otherwise hold.
- `WB_REQ`: `wb_cyc_o`=`wb_stb_o`=1 and all Wishbone outputs stable. The counter increments each cycle.
  - `wb_ack_i`=1: capture `wb_dat_i` (reads; writes capture 0), go to `RESP`, `err` flag 0.
  - `wb_err_i`=1: capture 0, go to `RESP`, `err` flag 1.
  - Counter reaches `TIMEOUT` without ack or err: capture 32'hDEAD_BEEF, go to `RESP`, `err` flag 1.
- `RESP`: `ready`=1 and `err_o`=flag for exactly one cycle, then go to `IDLE`. `rdata` holds its value until the next capture.
- `valid` asserted in `WB_REQ` or `RESP` is ignored: no latch, no queue. Initiators wait for `ready`.
- Priority in the same cycle: `wb_ack_i` > `wb_err_i` > timeout.
- `address[1:0]` is ignored. Byte selection comes only from `wstrb`.

## Timing
- Reset values (all outputs): `ready`=0, `err_o`=0, `rdata`=0, `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0, `wb_adr_o`=0, `wb_dat_o`=0, `wb_sel_o`=0. FSM returns to `IDLE` and the counter resets to 0.
- `valid` high at edge N: `wb_cyc_o`/`wb_stb_o` high after edge N.
- `wb_ack_i` sampled high at edge M: strobes low and `ready` high after edge M, for one cycle.
- Zero-wait-state slave (ack in the first strobe cycle): `ready` is 2 cycles after `valid`. Minimum request spacing is 3 cycles.
- Timeout: `ready` is `TIMEOUT`+1 cycles after `valid`.
- `rst_i` asserted mid-cycle: strobes drop at the next edge and no `ready` is issued for the aborted request.
- All outputs are registered. There is no combinational path from the Wishbone inputs to `ready`/`rdata`.

## Structure
- Shared package `iob_ethoc_pkg`:
  - FSM state encoding (2 bits).
  - `ETHOC_TIMEOUT_DATA` = 32'hDEAD_BEEF.
  - Register offsets: MODER 0x000, TX BD base 0x400, RX BD base 0x600.
- One natural sub-module, `iob_ethoc_timeout_cnt`: a loadable counter with clear, enable, and an `expired` output.
- The FSM and the request latches stay in the top module.

## Test plan
- Write MODER: `address`=0x000, `wdata`=0x0000A480, `wstrb`=0xF, slave acks after 1 cycle → `wb_we_o`=1, `wb_sel_o`=0xF, `wb_dat_o`=0x0000A480; `ready` 2 cycles after `valid`; `err_o`=0.
- Read back: `address`=0x000, `wstrb`=0, slave returns 0x0000A480 after 3 wait states → `wb_we_o`=0, `wb_sel_o`=0xF; `ready` 5 cycles after `valid` with `rdata`=0x0000A480.
- BD write `address`=0x602, `wstrb`=0x3 → `wb_adr_o`=0x600, `wb_sel_o`=0x3.
- Slave silent with `TIMEOUT`=8 → `ready` 9 cycles after `valid`, `rdata`=0xDEADBEEF, `err_o`=1; next request completes normally.
- `wb_err_i` and `wb_ack_i` asserted in the same cycle → ack wins (`err_o`=0). `wb_err_i` alone → `rdata`=0, `err_o`=1.
- Extra `valid` pulse during `WB_REQ` is ignored, giving exactly one `ready`. `rst_i` during `WB_REQ` → strobes low next cycle, no `ready`, all outputs at reset values.
